// File: rtl/slow_clk_period_meter.sv
// ---------------------------------------------------------------------------
// slow_clk_period_meter
//
// Measures the period and high time of a slow square wave that is
// asynchronous to clk, counted in clk cycles.  It recovers the division
// ratio and duty cycle of a divided clock or an external tick so that they
// can be checked in-system and reported through status registers.
// Supports single-shot and continuous measurement, abort, and a timeout.
//
// Parameters:
//   CNT_W        width of the cycle counters and measurement outputs
//   TIMEOUT_CYC  maximum cycles spent in ARM or MEASURE before giving up
//                (must be <= 2**CNT_W-1)
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-low reset
//   sig_in       slow signal to measure, asynchronous to clk
//   start        one-cycle pulse, begins a measurement from IDLE
//   abort        one-cycle pulse, cancels any measurement
//   continuous   1 = re-arm automatically at every closing edge
//   busy         high while in ARM or MEASURE
//   meas_valid   one-cycle pulse, new results on meas_period/meas_high
//   meas_period  cycles between successive rising edges
//   meas_high    cycles sig_in was high within that period
//   timeout_err  sticky timeout flag, cleared by an accepted start
// ---------------------------------------------------------------------------
module slow_clk_period_meter #(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             start,
  input  logic             abort,
  input  logic             continuous,
  output logic             busy,
  output logic             meas_valid,
  output logic [CNT_W-1:0] meas_period,
  output logic [CNT_W-1:0] meas_high,
  output logic             timeout_err
);

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] MEAS_LIMIT   = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] ARM_LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic sync0;
  logic sync1;
  logic sync_d;
  logic rise;
  logic lvl;

  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] tmo_cnt;

  logic arm_expired;
  logic meas_expired;
  logic accept_start;
  logic open_edge;
  logic close_edge;
  logic arm_step;
  logic arm_tmo;
  logic meas_step;
  logic meas_tmo;

  // Two-flop synchronizer plus one delay stage for edge detection.  Every
  // edge sees the same pipeline latency, so distances between rise pulses
  // equal distances between sig_in edges (to the clk sampling grid).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync0  <= 1'b0;
      sync1  <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      sync0  <= sig_in;
      sync1  <= sync0;
      sync_d <= sync1;
    end
  end

  assign rise = sync1 & ~sync_d;
  assign lvl  = sync1;

  // Limit compares.  In ARM tmo_cnt counts from 0, so the last allowed
  // cycle is TIMEOUT_CYC-1; in MEASURE period_cnt starts at 1 on the
  // opening edge, so it is compared against TIMEOUT_CYC itself.
  assign arm_expired  = (tmo_cnt == ARM_LAST_CNT);
  assign meas_expired = (period_cnt == MEAS_LIMIT);

  // Decoded events.  abort outranks everything, and a rise outranks a
  // timeout landing on the same cycle, so an edge arriving exactly at the
  // limit still yields a result.
  assign accept_start = (state == IDLE)    && start && !abort;
  assign open_edge    = (state == ARM)     && !abort && rise;
  assign arm_tmo      = (state == ARM)     && !abort && !rise && arm_expired;
  assign arm_step     = (state == ARM)     && !abort && !rise && !arm_expired;
  assign close_edge   = (state == MEASURE) && !abort && rise;
  assign meas_tmo     = (state == MEASURE) && !abort && !rise && meas_expired;
  assign meas_step    = (state == MEASURE) && !abort && !rise && !meas_expired;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.  continuous is looked at only on the closing edge,
  // so dropping it mid-measurement still lets the current period finish.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept_start) begin
          state_nxt = ARM;
        end
      end
      ARM: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (rise) begin
          state_nxt = MEASURE;
        end else if (arm_expired) begin
          state_nxt = IDLE;
        end
      end
      MEASURE: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (rise) begin
          state_nxt = continuous ? MEASURE : IDLE;
        end else if (meas_expired) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs decoded from the state alone.
  always_comb begin
    busy = 1'b0;
    if ((state == ARM) || (state == MEASURE)) begin
      busy = 1'b1;
    end
  end

  // ARM watchdog counter, restarted by every accepted start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (accept_start) begin
      tmo_cnt <= '0;
    end else if (arm_step) begin
      tmo_cnt <= tmo_cnt + CNT_ONE;
    end
  end

  // Period and high-time counters.  The opening-edge cycle counts as 1 for
  // both; in continuous mode the closing edge doubles as the next opening
  // edge, so both counters restart there without losing a cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_cnt <= '0;
      high_cnt   <= '0;
    end else if (open_edge || (close_edge && continuous)) begin
      period_cnt <= CNT_ONE;
      high_cnt   <= CNT_ONE;
    end else if (meas_step) begin
      period_cnt <= period_cnt + CNT_ONE;
      if (lvl) begin
        high_cnt <= high_cnt + CNT_ONE;
      end
    end
  end

  // Result registers.  They move only together with meas_valid, so the
  // last good result survives abort, timeout and idle periods.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meas_valid  <= 1'b0;
      meas_period <= '0;
      meas_high   <= '0;
    end else begin
      meas_valid <= close_edge;
      if (close_edge) begin
        meas_period <= period_cnt;
        meas_high   <= high_cnt;
      end
    end
  end

  // Sticky timeout flag: set by either timeout, cleared only by a start
  // that is actually accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timeout_err <= 1'b0;
    end else if (accept_start) begin
      timeout_err <= 1'b0;
    end else if (arm_tmo || meas_tmo) begin
      timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_slow_clk_period_meter.sv
// ---------------------------------------------------------------------------
// tb_slow_clk_period_meter
//
// Self-checking bench for slow_clk_period_meter.  sig_in is synthesised as
// a square wave of known period/high time (directed and $urandom cases);
// expected results follow directly from those wave parameters.  A second
// instance with a short timeout covers the ARM timeout case.
// ---------------------------------------------------------------------------
module tb_slow_clk_period_meter;

  localparam int CNT_W     = 16;
  localparam int TMO_MAIN  = 1500;
  localparam int TMO_SHORT = 100;

  logic             clk;
  logic             reset;
  logic             sig_in;
  logic             start;
  logic             abort;
  logic             continuous;

  logic             busy;
  logic             meas_valid;
  logic [CNT_W-1:0] meas_period;
  logic [CNT_W-1:0] meas_high;
  logic             timeout_err;

  logic             t_busy;
  logic             t_valid;
  logic [CNT_W-1:0] t_period;
  logic [CNT_W-1:0] t_high;
  logic             t_err;

  int checks      = 0;
  int errors      = 0;
  int cyc         = 0;
  int t_valid_cnt = 0;
  int last_period = 0;
  int last_high   = 0;
  int obs_period[$];
  int obs_high[$];
  int obs_cyc[$];

  slow_clk_period_meter #(
    .CNT_W      (CNT_W),
    .TIMEOUT_CYC(TMO_MAIN)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sig_in     (sig_in),
    .start      (start),
    .abort      (abort),
    .continuous (continuous),
    .busy       (busy),
    .meas_valid (meas_valid),
    .meas_period(meas_period),
    .meas_high  (meas_high),
    .timeout_err(timeout_err)
  );

  slow_clk_period_meter #(
    .CNT_W      (CNT_W),
    .TIMEOUT_CYC(TMO_SHORT)
  ) dut_tmo (
    .clk        (clk),
    .reset      (reset),
    .sig_in     (sig_in),
    .start      (start),
    .abort      (abort),
    .continuous (continuous),
    .busy       (t_busy),
    .meas_valid (t_valid),
    .meas_period(t_period),
    .meas_high  (t_high),
    .timeout_err(t_err)
  );

  // 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle counter used to time-stamp results.
  always @(posedge clk) cyc <= cyc + 1;

  // Result monitor: log every meas_valid pulse away from the active edge.
  always @(negedge clk) begin
    if (meas_valid === 1'b1) begin
      obs_period.push_back(int'(meas_period));
      obs_high.push_back(int'(meas_high));
      obs_cyc.push_back(cyc);
    end
    if (t_valid === 1'b1) begin
      t_valid_cnt = t_valid_cnt + 1;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    repeat (90000) @(posedge clk);
    $display("[TB] FAIL watchdog: observed still running after %0d cycles, required finish", 90000);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp)
    else begin
      errors = errors + 1;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and move to a fixed phase inside the cycle.
  task automatic step(input int phase);
    @(posedge clk);
    #(phase);
  endtask

  task automatic pulse(input logic s, input logic a);
    @(posedge clk);
    #1;
    start = s;
    abort = a;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  // n full periods of (p, h) followed by one closing rising edge.
  // drop_at != 0 clears continuous after the high phase of that period.
  task automatic drive_wave(input int p, input int h, input int n, input int phase, input int drop_at);
    for (int k = 1; k <= n; k++) begin
      sig_in = 1'b1;
      repeat (h) step(phase);
      if (k == drop_at) continuous = 1'b0;
      sig_in = 1'b0;
      repeat (p - h) step(phase);
    end
    sig_in = 1'b1;
    repeat (h) step(phase);
    sig_in = 1'b0;
    repeat (8) step(phase);
  endtask

  // One measurement run.  Reference: each closing edge that the block sees
  // while measuring gives (p, h); single-shot yields the first period only,
  // continuous yields all n (or up to drop_at), and a period longer than the
  // timeout yields nothing but a sticky timeout.
  task automatic apply_stimulus(input int p, input int h, input int n, input bit cont,
                                input int drop_at, input int phase);
    int    n_exp;
    string tg;
    obs_period.delete();
    obs_high.delete();
    obs_cyc.delete();
    continuous = cont;
    pulse(1'b1, 1'b0);
    repeat (3) step(phase);
    drive_wave(p, h, n, phase, drop_at);
    if (cont && (drop_at == 0)) pulse(1'b0, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);

    if (p > TMO_MAIN)        n_exp = 0;
    else if (drop_at != 0)   n_exp = drop_at;
    else if (cont)           n_exp = n;
    else                     n_exp = 1;

    tg = $sformatf("p%0d_h%0d_n%0d_c%0d", p, h, n, cont);
    check_output({tg, " result_count"}, obs_period.size(), n_exp);
    for (int i = 0; (i < n_exp) && (i < obs_period.size()); i++) begin
      check_output($sformatf("%s period[%0d]", tg, i), obs_period[i], p);
      check_output($sformatf("%s high[%0d]", tg, i), obs_high[i], h);
      if (i > 0) begin
        check_output($sformatf("%s valid_gap[%0d]", tg, i), obs_cyc[i] - obs_cyc[i-1], p);
      end
    end
    if (n_exp > 0) begin
      last_period = p;
      last_high   = h;
    end
    check_output({tg, " busy_after"}, busy, 0);
    check_output({tg, " timeout_err"}, timeout_err, (p > TMO_MAIN) ? 1 : 0);
    check_output({tg, " hold_period"}, meas_period, last_period);
    check_output({tg, " hold_high"}, meas_high, last_high);
    continuous = 1'b0;
  endtask

  initial begin
    int n0;
    int tv0;
    int p;
    int h;
    int n;
    int ph;
    bit c;

    reset      = 1'b0;
    sig_in     = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    continuous = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset busy", busy, 0);
    check_output("reset meas_valid", meas_valid, 0);
    check_output("reset meas_period", meas_period, 0);
    check_output("reset meas_high", meas_high, 0);
    check_output("reset timeout_err", timeout_err, 0);
    reset = 1'b1;
    repeat (3) @(posedge clk);

    $display("[TB] single-shot and continuous divide-by-1000");
    apply_stimulus(1000, 500, 1, 1'b0, 0, 1);
    apply_stimulus(1000, 500, 5, 1'b1, 0, 1);
    apply_stimulus(1000, 500, 7, 1'b1, 6, 1);

    $display("[TB] 37/5 with phase-shifted edges");
    apply_stimulus(37, 5, 3, 1'b0, 0, 7);
    apply_stimulus(37, 5, 3, 1'b1, 0, 3);

    $display("[TB] measure-timeout boundary");
    apply_stimulus(TMO_MAIN, 700, 1, 1'b0, 0, 2);
    apply_stimulus(TMO_MAIN + 1, 700, 1, 1'b0, 0, 2);

    $display("[TB] random waves");
    for (int t = 0; t < 6; t++) begin
      p  = int'($urandom_range(200, 4));
      h  = int'($urandom_range(p - 2, 2));
      n  = int'($urandom_range(4, 1));
      c  = bit'($urandom_range(1, 0));
      ph = int'($urandom_range(9, 1));
      apply_stimulus(p, h, n, c, 0, ph);
    end

    $display("[TB] abort mid-measurement");
    n0 = obs_period.size();
    pulse(1'b1, 1'b0);
    repeat (3) step(1);
    sig_in = 1'b1;
    repeat (300) step(1);
    pulse(1'b0, 1'b1);
    @(negedge clk);
    check_output("abort busy_next", busy, 0);
    repeat (200) step(1);
    sig_in = 1'b0;
    repeat (500) step(1);
    sig_in = 1'b1;
    repeat (10) step(1);
    sig_in = 1'b0;
    repeat (6) step(1);
    check_output("abort no_valid", obs_period.size(), n0);
    check_output("abort hold_period", meas_period, last_period);
    check_output("abort hold_high", meas_high, last_high);
    pulse(1'b1, 1'b1);
    @(negedge clk);
    check_output("start_abort busy", busy, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("start_abort busy_later", busy, 0);

    $display("[TB] reset mid-measurement");
    pulse(1'b1, 1'b0);
    repeat (3) step(1);
    sig_in = 1'b1;
    repeat (300) step(1);
    n0 = obs_period.size();
    #2;
    reset = 1'b0;
    #1;
    check_output("midreset busy", busy, 0);
    check_output("midreset meas_valid", meas_valid, 0);
    check_output("midreset meas_period", meas_period, 0);
    check_output("midreset meas_high", meas_high, 0);
    check_output("midreset timeout_err", timeout_err, 0);
    sig_in = 1'b0;
    repeat (4) step(1);
    reset = 1'b1;
    repeat (4) step(1);
    check_output("midreset no_valid", obs_period.size(), n0);
    last_period = 0;
    last_high   = 0;
    apply_stimulus(1000, 500, 1, 1'b0, 0, 1);

    $display("[TB] arm timeout on short-timeout instance");
    pulse(1'b0, 1'b1);
    sig_in = 1'b0;
    repeat (4) @(posedge clk);
    tv0 = t_valid_cnt;
    pulse(1'b1, 1'b0);
    repeat (TMO_SHORT - 1) @(posedge clk);
    @(negedge clk);
    check_output("tmo busy_before", t_busy, 1);
    check_output("tmo err_before", t_err, 0);
    @(posedge clk);
    @(negedge clk);
    check_output("tmo err_set", t_err, 1);
    check_output("tmo busy_after", t_busy, 0);
    check_output("tmo no_valid", t_valid_cnt, tv0);
    check_output("tmo hold_period", t_period, 0);
    check_output("tmo hold_high", t_high, 0);
    pulse(1'b1, 1'b0);
    @(negedge clk);
    check_output("tmo err_cleared", t_err, 0);
    check_output("tmo busy_restart", t_busy, 1);
    pulse(1'b0, 1'b1);
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
